led_blink_monitor: RTL

//  Receive-side counterpart of the LED blinker: samples an asynchronous blink line,

---
 rtl/led_blink_monitor_pkg.sv | 21 ++
 rtl/led_blink_monitor_edge_sync.sv | 89 ++++++++
 rtl/led_blink_monitor.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/led_blink_monitor_pkg.sv
// -----------------------------------------------------------------------------
// led_blink_monitor_pkg
// Shared definitions for the LED blink monitor.
//   - mon_state_e     : monitor FSM states (ARM / HIGH / LOW / STUCK)
//   - SYNC_DEPTH      : number of flops in the LED input synchronizer
//   - DEFAULT_TIMEOUT : default idle time, in cycles, before STUCK asserts
// Optional build macro used by the monitor: BLINK_MON_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
package led_blink_monitor_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,  // waiting for the first reference rise
    ST_HIGH  = 2'd1,  // line high, high-time counter running
    ST_LOW   = 2'd2,  // line low, next rise closes a period
    ST_STUCK = 2'd3   // no edge for TIMEOUT cycles
  } mon_state_e;

  localparam int unsigned SYNC_DEPTH      = 2;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/led_blink_monitor_edge_sync.sv
// -----------------------------------------------------------------------------
// led_blink_monitor_edge_sync
// Brings the asynchronous LED line into the clock domain and produces
// registered one-cycle rise/fall pulses plus the accepted line level.
// Build macro BLINK_MON_DEBOUNCE_EN: when defined, a new level is accepted
// only after DEB_LEN consecutive synchronized samples differ from the current
// level; shorter pulses never produce an edge.
// Ports:
//   clk_i   in  clock
//   rst_i   in  asynchronous active-high reset
//   led_i   in  raw blink line (asynchronous)
//   rise_o  out one-cycle pulse on an accepted 0->1 change
//   fall_o  out one-cycle pulse on an accepted 1->0 change
//   level_o out currently accepted line level
// -----------------------------------------------------------------------------
module led_blink_monitor_edge_sync
  import led_blink_monitor_pkg::*;
#(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic led_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);

`ifdef BLINK_MON_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  // Without the filter a single differing sample is enough.
  localparam int unsigned FILT_LEN = DEB_EN ? DEB_LEN : 32'd1;
  localparam int unsigned DW       = $clog2(FILT_LEN + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(FILT_LEN - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [DW-1:0]         deb_q;
  logic                  lvl_q;
  logic                  rise_q;
  logic                  fall_q;
  logic                  sync_lvl;
  logic                  accept;

  assign sync_lvl = sync_q[SYNC_DEPTH-1];
  assign accept   = (sync_lvl != lvl_q) && (deb_q == DEB_LAST);

  // Metastability synchronizer on the raw LED line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], led_i};
    end
  end

  // Run-length counter of samples that disagree with the accepted level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q <= '0;
    end else if ((sync_lvl == lvl_q) || accept) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_q + 1'b1;
    end
  end

  // Accepted level and registered edge pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & sync_lvl;
      fall_q <= accept & ~sync_lvl;
      if (accept) begin
        lvl_q <= sync_lvl;
      end
    end
  end

  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/led_blink_monitor.sv
// -----------------------------------------------------------------------------
// led_blink_monitor
// Measures an asynchronous blink line: period (rise to rise), high time and
// number of rises, all in clk_i cycles, and flags a line that stops toggling.
// Build macro BLINK_MON_DEBOUNCE_EN enables the input debounce filter.
// Ports:
//   clk_i        in  clock
//   rst_i        in  asynchronous active-high reset
//   led_i        in  blink line, asynchronous to clk_i
//   period_o     out last rise-to-rise distance (saturating, CNT_W bits)
//   high_time_o  out last high-phase length (saturating, CNT_W bits)
//   period_vld_o out one-cycle pulse when period_o/high_time_o update
//   blink_cnt_o  out qualified rises since reset (wraps, BCNT_W bits)
//   stuck_o      out line has not changed for TIMEOUT cycles
//   stuck_lvl_o  out level the line is stuck at (valid while stuck_o=1)
// -----------------------------------------------------------------------------
module led_blink_monitor
  import led_blink_monitor_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned BCNT_W  = 16,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned DEB_LEN = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              led_i,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  high_time_o,
  output logic              period_vld_o,
  output logic [BCNT_W-1:0] blink_cnt_o,
  output logic              stuck_o,
  output logic              stuck_lvl_o
);

  // Idle counter is sized from TIMEOUT so it is independent of CNT_W.
  localparam int unsigned     IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  mon_state_e        state_q;
  logic [CNT_W-1:0]  period_cnt_q;
  logic [CNT_W-1:0]  high_cnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  high_time_q;
  logic              period_vld_q;
  logic [BCNT_W-1:0] blink_cnt_q;
  logic              stuck_q;
  logic              stuck_lvl_q;

  logic [CNT_W-1:0]  period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_d;
  logic [IDLE_W-1:0] idle_d;
  logic              rise;
  logic              fall;
  logic              level;
  logic              any_edge;
  logic              timeout;

  led_blink_monitor_edge_sync #(
    .DEB_LEN (DEB_LEN)
  ) u_edge_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .led_i   (led_i),
    .rise_o  (rise),
    .fall_o  (fall),
    .level_o (level)
  );

  // Saturating increments; the idle counter never passes IDLE_MAX.
  assign period_cnt_d = (&period_cnt_q) ? period_cnt_q : period_cnt_q + 1'b1;
  assign high_cnt_d   = (&high_cnt_q) ? high_cnt_q : high_cnt_q + 1'b1;
  assign idle_d       = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
  assign any_edge     = rise | fall;
  // An edge in the same cycle always beats the timeout.
  assign timeout      = ~any_edge && (idle_q != IDLE_MAX) && (idle_d == IDLE_MAX);

  // Monitor FSM together with its counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_ARM;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      idle_q       <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      period_vld_q <= 1'b0;
      blink_cnt_q  <= '0;
      stuck_q      <= 1'b0;
      stuck_lvl_q  <= 1'b0;
    end else begin
      period_vld_q <= 1'b0;
      period_cnt_q <= rise ? CNT_ONE : period_cnt_d;
      idle_q       <= any_edge ? '0 : idle_d;
      if (rise) begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      if (timeout) begin
        state_q     <= ST_STUCK;
        stuck_q     <= 1'b1;
        stuck_lvl_q <= level;
      end else begin
        case (state_q)
          ST_ARM: begin
            if (rise) begin
              state_q    <= ST_HIGH;
              high_cnt_q <= CNT_ONE;
            end
          end
          ST_HIGH: begin
            // High time freezes at the fall and is read at the next rise.
            if (fall) begin
              state_q <= ST_LOW;
            end else begin
              high_cnt_q <= high_cnt_d;
            end
          end
          ST_LOW: begin
            if (rise) begin
              state_q      <= ST_HIGH;
              period_q     <= period_cnt_q;
              high_time_q  <= high_cnt_q;
              period_vld_q <= 1'b1;
              high_cnt_q   <= CNT_ONE;
            end
          end
          ST_STUCK: begin
            // Any edge leaves STUCK, but the next period has no reference.
            if (any_edge) begin
              state_q <= ST_ARM;
              stuck_q <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_ARM;
          end
        endcase
      end
    end
  end

  assign period_o     = period_q;
  assign high_time_o  = high_time_q;
  assign period_vld_o = period_vld_q;
  assign blink_cnt_o  = blink_cnt_q;
  assign stuck_o      = stuck_q;
  assign stuck_lvl_o  = stuck_lvl_q;

endmodule
